// File: rtl/lsu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_issue_arbiter
//   Consumer side of the 2-entry LSU bypass FIFO. Captures the FIFO head into a
//   one-entry issue register, pops it in the same cycle, and presents it to the
//   load or store unit under a valid/ready handshake. Keeps a count of loads
//   accepted but not yet completed, so a store is only issued once no load is
//   in flight.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           pipeline flush (drops the issue slot and load count)
//   lsu_ctrl_i[84:0]  FIFO head {valid, vaddr, overflow, data, be, fu, op, id}
//   pop_ld_o          combinational pop pulse to the FIFO (loads, illegal fu)
//   pop_st_o          combinational pop pulse to the FIFO (stores)
//   req_o[84:0]       captured request, shared by both units
//   ld_valid_o/ld_ready_i   load unit handshake
//   st_valid_o/st_ready_i   store unit handshake
//   ld_done_i         one pulse per completed load
//   busy_o            request pending or loads outstanding
//   illegal_o         pulse when a head with an unknown fu is dropped
// -----------------------------------------------------------------------------
module lsu_issue_arbiter #(
  parameter int unsigned MAX_OUT_LD = 2,
  parameter logic [3:0]  FU_LOAD    = 4'd1,
  parameter logic [3:0]  FU_STORE   = 4'd2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [84:0] lsu_ctrl_i,
  output logic        pop_ld_o,
  output logic        pop_st_o,
  output logic [84:0] req_o,
  output logic        ld_valid_o,
  input  logic        ld_ready_i,
  output logic        st_valid_o,
  input  logic        st_ready_i,
  input  logic        ld_done_i,
  output logic        busy_o,
  output logic        illegal_o
);

  localparam int unsigned REQ_W = 85;
  localparam int unsigned CNT_W = $clog2(MAX_OUT_LD + 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] vaddr;
    logic        overflow;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  fu;
    logic [7:0]  operation;
    logic [2:0]  trans_id;
  } lsu_req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_PEND = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  lsu_req_t         req_q, req_d;
  logic [CNT_W-1:0] ld_out_q, ld_out_d;
  logic [CNT_W-1:0] ld_out_upd;

  lsu_req_t head;
  logic     ld_hs;
  logic     st_hs;
  logic     slot_free;
  logic     load_ok;
  logic     store_ok;
  logic     pop_ld_c;
  logic     pop_st_c;
  logic     illegal_c;

  assign head = lsu_req_t'(lsu_ctrl_i);

  // Handshakes on the currently presented request
  assign ld_hs     = (state_q == LD_PEND) && ld_ready_i;
  assign st_hs     = (state_q == ST_PEND) && st_ready_i;
  assign slot_free = (state_q == IDLE) || ld_hs || st_hs;

  // Outstanding-load count after this cycle's accept/complete, saturating at 0
  always_comb begin
    ld_out_upd = ld_out_q;
    if (ld_hs && !ld_done_i) begin
      ld_out_upd = ld_out_q + CNT_W'(1);
    end else if (!ld_hs && ld_done_i && (ld_out_q != '0)) begin
      ld_out_upd = ld_out_q - CNT_W'(1);
    end
  end

  // A load may take the slot as long as the updated count leaves room; a store
  // waits for the count to read zero with no load being accepted this cycle.
  assign load_ok  = ld_out_upd < CNT_W'(MAX_OUT_LD);
  assign store_ok = (ld_out_q == '0) && !ld_hs;

  // Next-state, capture and pop decode
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ld_out_d  = ld_out_upd;
    pop_ld_c  = 1'b0;
    pop_st_c  = 1'b0;
    illegal_c = 1'b0;

    if (slot_free) begin
      state_d = IDLE;
    end

    if (flush_i) begin
      state_d  = IDLE;
      req_d    = '0;
      ld_out_d = '0;
    end else if (slot_free && head.valid) begin
      if (head.fu == FU_LOAD) begin
        if (load_ok) begin
          req_d    = head;
          pop_ld_c = 1'b1;
          state_d  = LD_PEND;
        end
      end else if (head.fu == FU_STORE) begin
        if (store_ok) begin
          req_d    = head;
          pop_st_c = 1'b1;
          state_d  = ST_PEND;
        end
      end else begin
        // Unknown fu: drain it from the FIFO without issuing anything
        pop_ld_c  = 1'b1;
        illegal_c = 1'b1;
      end
    end
  end

  // State, issue register and load counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_q    <= '0;
      ld_out_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ld_out_q <= ld_out_d;
    end
  end

  // Combinational pulses are held low while reset is asserted
  assign pop_ld_o   = pop_ld_c && rst_ni;
  assign pop_st_o   = pop_st_c && rst_ni;
  assign illegal_o  = illegal_c && rst_ni;

  assign req_o      = REQ_W'(req_q);
  assign ld_valid_o = (state_q == LD_PEND);
  assign st_valid_o = (state_q == ST_PEND);
  assign busy_o     = (state_q != IDLE) || (ld_out_q != '0);

  // Design invariants
  a_pop_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_ld_o && pop_st_o));

  a_ld_out_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ld_out_q <= CNT_W'(MAX_OUT_LD));

  a_ld_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ld_valid_o && !ld_ready_i && !flush_i) |=> (ld_valid_o && $stable(req_o)));

  a_st_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (st_valid_o && !st_ready_i && !flush_i) |=> (st_valid_o && $stable(req_o)));

endmodule

// File: tb/tb_lsu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsu_issue_arbiter
//   Bench for lsu_issue_arbiter: directed scenarios followed by random traffic,
//   every output compared each cycle against a transaction-level model of the
//   issue slot, the outstanding-load count and the FIFO contents.
// -----------------------------------------------------------------------------
module tb_lsu_issue_arbiter;

  localparam int unsigned MAX_LD = 2;
  localparam logic [3:0]  FU_LD  = 4'd1;
  localparam logic [3:0]  FU_ST  = 4'd2;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic [84:0] lsu_ctrl_i;
  logic        pop_ld_o;
  logic        pop_st_o;
  logic [84:0] req_o;
  logic        ld_valid_o;
  logic        ld_ready_i;
  logic        st_valid_o;
  logic        st_ready_i;
  logic        ld_done_i;
  logic        busy_o;
  logic        illegal_o;

  lsu_issue_arbiter #(
    .MAX_OUT_LD (MAX_LD),
    .FU_LOAD    (FU_LD),
    .FU_STORE   (FU_ST)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .lsu_ctrl_i (lsu_ctrl_i),
    .pop_ld_o   (pop_ld_o),
    .pop_st_o   (pop_st_o),
    .req_o      (req_o),
    .ld_valid_o (ld_valid_o),
    .ld_ready_i (ld_ready_i),
    .st_valid_o (st_valid_o),
    .st_ready_i (st_ready_i),
    .ld_done_i  (ld_done_i),
    .busy_o     (busy_o),
    .illegal_o  (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: what is sitting in the issue slot (0 none, 1 load, 2 store), its
  // payload, how many loads are in flight, and what the FIFO holds.
  int          m_kind = 0;
  int          m_out  = 0;
  logic [84:0] m_req  = '0;
  logic [84:0] fifo[$];
  int          n_pop_ld_dut = 0;

  task automatic check_eq(input string tag, input logic [84:0] got, input logic [84:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [84:0] mk_head(input logic [3:0] fu, input logic [2:0] tid);
    logic [84:0] h;
    h = {1'b1, 32'($urandom()), 1'($urandom()), 32'($urandom()), 4'($urandom()),
         fu, 8'($urandom()), tid};
    return h;
  endfunction

  function automatic logic [84:0] rand_head();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5)      return mk_head(FU_LD, 3'($urandom()));
    else if (r < 9) return mk_head(FU_ST, 3'($urandom()));
    else            return mk_head(4'($urandom_range(3, 15)), 3'($urandom()));
  endfunction

  // One clock cycle: drive inputs, compare all outputs, advance the model
  task automatic step(input logic fl, input logic lr, input logic sr, input logic ld);
    logic [84:0] hd;
    logic        e_pl, e_ps, e_il, free, ldacc, cap;
    int          out_after, nk;
    @(negedge clk_i);
    hd = (fifo.size() != 0) ? fifo[0] : '0;
    flush_i    = fl;
    lsu_ctrl_i = hd;
    ld_ready_i = lr;
    st_ready_i = sr;
    ld_done_i  = ld;
    #1;
    ldacc     = (m_kind == 1) && lr;
    free      = (m_kind == 0) || ldacc || ((m_kind == 2) && sr);
    out_after = m_out + (ldacc ? 1 : 0) - (ld ? 1 : 0);
    if (out_after < 0) out_after = 0;
    e_pl = 1'b0; e_ps = 1'b0; e_il = 1'b0; cap = 1'b0;
    nk   = free ? 0 : m_kind;
    if (!fl && free && hd[84]) begin
      if (hd[14:11] == FU_LD) begin
        if (out_after < int'(MAX_LD)) begin e_pl = 1'b1; cap = 1'b1; nk = 1; end
      end else if (hd[14:11] == FU_ST) begin
        if (m_out == 0 && !ldacc) begin e_ps = 1'b1; cap = 1'b1; nk = 2; end
      end else begin
        e_pl = 1'b1; e_il = 1'b1;
      end
    end
    check_eq("ld_valid", ld_valid_o, (m_kind == 1));
    check_eq("st_valid", st_valid_o, (m_kind == 2));
    check_eq("req",      req_o,      m_req);
    check_eq("busy",     busy_o,     (m_kind != 0) || (m_out != 0));
    check_eq("pop_ld",   pop_ld_o,   e_pl);
    check_eq("pop_st",   pop_st_o,   e_ps);
    check_eq("illegal",  illegal_o,  e_il);
    if (pop_ld_o) n_pop_ld_dut++;
    @(posedge clk_i);
    if (fl) begin
      m_kind = 0; m_out = 0; m_req = '0;
    end else begin
      m_kind = nk; m_out = out_after;
      if (cap) m_req = hd;
    end
    if (e_pl || e_ps) fifo.delete(0);
  endtask

  // Complete all outstanding work, bounded
  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (m_kind != 0 || m_out != 0 || fifo.size() != 0) step(1'b0, 1'b1, 1'b1, 1'b1);
    end
  endtask

  initial begin
    logic [84:0] r0;
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    lsu_ctrl_i = mk_head(FU_LD, 3'd1);
    ld_ready_i = 1'b0;
    st_ready_i = 1'b0;
    ld_done_i  = 1'b0;

    // Reset: every output low even with a valid head presented
    #12;
    check_eq("rst_pop_ld",  pop_ld_o,   1'b0);
    check_eq("rst_pop_st",  pop_st_o,   1'b0);
    check_eq("rst_req",     req_o,      '0);
    check_eq("rst_ldv",     ld_valid_o, 1'b0);
    check_eq("rst_stv",     st_valid_o, 1'b0);
    check_eq("rst_busy",    busy_o,     1'b0);
    check_eq("rst_illegal", illegal_o,  1'b0);
    lsu_ctrl_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single load, trans_id 3: pop now, valid next cycle, count visible after
    fifo.push_back(mk_head(FU_LD, 3'd3));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("ld1_valid", ld_valid_o, 1'b1);
    r0 = req_o;
    check_eq("ld1_tid", {82'd0, r0[2:0]}, 85'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("ld1_busy_cnt", busy_o, 1'b1);
    drain();

    // Three loads back to back with a two-load ceiling
    n_pop_ld_dut = 0;
    repeat (3) fifo.push_back(mk_head(FU_LD, 3'($urandom())));
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("b2b_pops", 85'(n_pop_ld_dut), 85'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("b2b_pop3", 85'(n_pop_ld_dut), 85'd3);
    drain();

    // Store held behind an in-flight load, then held by a slow store unit
    fifo.push_back(mk_head(FU_LD, 3'd4));
    fifo.push_back(mk_head(FU_ST, 3'd5));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    r0 = req_o;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check_eq("st_hold_valid", st_valid_o, 1'b1);
      check_eq("st_hold_req",   req_o,      r0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Unknown fu is popped and flagged for one cycle only
    fifo.push_back(mk_head(4'd3, 3'd6));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Flush while a load is pending with one already accepted
    fifo.push_back(mk_head(FU_LD, 3'd1));
    fifo.push_back(mk_head(FU_LD, 3'd2));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("flush_ldv",  ld_valid_o, 1'b0);
    check_eq("flush_busy", busy_o,     1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a store is pending
    fifo.push_back(mk_head(FU_ST, 3'd7));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    lsu_ctrl_i = '0; flush_i = 1'b0; ld_ready_i = 1'b0; st_ready_i = 1'b0; ld_done_i = 1'b0;
    #1;
    check_eq("arst_pre_stv", st_valid_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check_eq("arst_stv",  st_valid_o, 1'b0);
    check_eq("arst_busy", busy_o,     1'b0);
    check_eq("arst_req",  req_o,      '0);
    m_kind = 0; m_out = 0; m_req = '0;
    #1 rst_ni = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (fifo.size() < 2 && $urandom_range(0, 99) < 60) fifo.push_back(rand_head());
      step(1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 25));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
